// File: rtl/log_offset_decoder.sv
// rtl/log_offset_decoder.sv - inverse shift_offset/log_offset LUT, sequential nearest-match scan
//
// Purpose:
//   Converts a captured 16-bit log-offset word back to the 4-bit shift_offset
//   that produced it. The 16-entry offset table is scanned one entry per
//   cycle. An exact match ends the scan early. Otherwise the entry with the
//   smallest Hamming distance wins, and the lowest index wins on a tie.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake (ready only while idle)
//   log_word[15:0]           word to decode
//   out_valid/out_ready      result handshake (valid held until accepted)
//   shift_offset[3:0]        decoded shift code
//   distance[4:0]            Hamming distance to the chosen entry
//   exact                    distance == 0
//   hit                      distance <= MAX_DIST
module log_offset_decoder #(
  parameter logic [4:0] MAX_DIST = 5'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] log_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  shift_offset,
  output logic [4:0]  distance,
  output logic        exact,
  output logic        hit
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  best_idx_q, best_idx_d;
  logic [4:0]  best_dist_q, best_dist_d;
  logic [3:0]  shift_q, shift_d;
  logic [4:0]  dist_q, dist_d;
  logic        exact_q, exact_d;
  logic        hit_q, hit_d;

  logic [4:0]  cur_dist;
  logic        better;
  logic [3:0]  sel_idx;
  logic [4:0]  sel_dist;

  function automatic logic [15:0] table_entry(input logic [3:0] i);
    logic [15:0] e;
    case (i)
      4'd0:    e = 16'h0000;
      4'd1:    e = 16'h0000;
      4'd2:    e = 16'hA98A;
      4'd3:    e = 16'hF44F;
      4'd4:    e = 16'h9A29;
      4'd5:    e = 16'hCAA9;
      4'd6:    e = 16'hCAA9;
      4'd7:    e = 16'hCAA9;
      4'd8:    e = 16'h0160;
      4'd9:    e = 16'h03E0;
      4'd10:   e = 16'h0A20;
      4'd11:   e = 16'h1BA1;
      4'd12:   e = 16'h4B04;
      4'd13:   e = 16'hCBFC;
      4'd14:   e = 16'hFFFF;
      default: e = 16'hFFFF;
    endcase
    return e;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  assign cur_dist = popcount16(word_q ^ table_entry(idx_q));
  // Strict compare keeps the earlier (lower) index on a tie; an exact match
  // is always "better" since best_dist starts at 31.
  assign better   = (cur_dist < best_dist_q);
  assign sel_idx  = better ? idx_q : best_idx_q;
  assign sel_dist = better ? cur_dist : best_dist_q;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    shift_d     = shift_q;
    dist_d      = dist_q;
    exact_d     = exact_q;
    hit_d       = hit_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d      = log_word;
          idx_d       = 4'd0;
          best_idx_d  = 4'd0;
          best_dist_d = 5'd31;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        best_idx_d  = sel_idx;
        best_dist_d = sel_dist;
        // Entry 15 is folded into the final result in the same cycle.
        if (cur_dist == 5'd0 || idx_q == 4'd15) begin
          shift_d = sel_idx;
          dist_d  = sel_dist;
          exact_d = (sel_dist == 5'd0);
          hit_d   = (sel_dist <= MAX_DIST);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= 16'h0000;
      idx_q       <= 4'd0;
      best_idx_q  <= 4'd0;
      best_dist_q <= 5'd31;
      shift_q     <= 4'd0;
      dist_q      <= 5'd0;
      exact_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      shift_q     <= shift_d;
      dist_q      <= dist_d;
      exact_q     <= exact_d;
      hit_q       <= hit_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign shift_offset = shift_q;
  assign distance     = dist_q;
  assign exact        = exact_q;
  assign hit          = hit_q;

endmodule
